// File: rtl/bit_permute_pipe_pkg.sv
// Shared definitions for the bit permutation pipeline.
// Holds the mode encoding used by the pipeline and its permute core, plus
// elaboration-time parameter legality checks.
package bit_permute_pipe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS     = 2'd0;
  localparam mode_t MODE_BITREV   = 2'd1;
  localparam mode_t MODE_BYTESWAP = 2'd2;
  localparam mode_t MODE_FIELDREV = 2'd3;

  // Data width must be a whole number of bytes so byte swap is well defined.
  function automatic bit width_is_valid(int unsigned width);
    return (width >= 8) && ((width % 8) == 0);
  endfunction

  // The length field must be able to encode WIDTH itself.
  function automatic bit lenw_is_valid(int unsigned width, int unsigned lenw);
    return (64'(1) << lenw) > 64'(width);
  endfunction

endpackage

// File: rtl/bit_permute_pipe_if.sv
// Handshake bundle for bit_permute_pipe.
// Input side : in_valid/in_ready/in_data/in_mode/in_len (producer -> unit)
// Output side: out_valid/out_ready/out_data (unit -> consumer)
// Status     : busy (any pipeline stage occupied)
// master = the surrounding datapath, slave = the permute pipeline.
interface bit_permute_pipe_if
  import bit_permute_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  mode_t            in_mode;
  logic [LENW-1:0]  in_len;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output in_len,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  in_len,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

endinterface

// File: rtl/bit_permute_pipe_permute_core.sv
// Combinational permute core.
// Ports:
//   i_data   : operand
//   i_mode   : 0 pass, 1 bit reverse, 2 byte swap, 3 low-field bit reverse
//   i_len    : field length for mode 3 (clamped to WIDTH)
//   o_result : permuted operand
// Purely combinational so it can be reused outside the pipeline.
module bit_permute_pipe_permute_core
  import bit_permute_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
) (
  input  logic [WIDTH-1:0] i_data,
  input  mode_t            i_mode,
  input  logic [LENW-1:0]  i_len,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned     NumBytes = WIDTH / 8;
  localparam logic [LENW-1:0] WidthLen = LENW'(WIDTH);

  logic [WIDTH-1:0] w_bitrev;
  logic [WIDTH-1:0] w_byteswap;
  logic [WIDTH-1:0] w_field_mask;
  logic [WIDTH-1:0] w_field;
  logic [LENW-1:0]  w_len_eff;
  logic [LENW-1:0]  w_shamt;

  always_comb begin
    w_bitrev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bitrev[i] = i_data[WIDTH-1-i];
    end
  end

  always_comb begin
    w_byteswap = '0;
    for (int k = 0; k < NumBytes; k++) begin
      w_byteswap[8*k +: 8] = i_data[8*(NumBytes-1-k) +: 8];
    end
  end

  // Field reverse of the low L bits equals the full reversal shifted down by
  // WIDTH-L; the mask keeps the untouched upper bits from the original word.
  // L=0 gives a shift of WIDTH, which empties both the shifted word and mask.
  assign w_len_eff    = (i_len > WidthLen) ? WidthLen : i_len;
  assign w_shamt      = WidthLen - w_len_eff;
  assign w_field_mask = {WIDTH{1'b1}} >> w_shamt;
  assign w_field      = ((w_bitrev >> w_shamt) & w_field_mask) | (i_data & ~w_field_mask);

  always_comb begin
    o_result = i_data;
    unique case (i_mode)
      MODE_PASS:     o_result = i_data;
      MODE_BITREV:   o_result = w_bitrev;
      MODE_BYTESWAP: o_result = w_byteswap;
      MODE_FIELDREV: o_result = w_field;
    endcase
  end

endmodule

// File: rtl/bit_permute_pipe.sv
// Two-stage elastic bit permutation pipeline.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, discards all in-flight words
//   bus   : slave side of bit_permute_pipe_if (valid/ready in, valid/ready
//           out, busy status)
// S1 captures data/mode/len at accept; S2 holds the permuted result and
// drives out_data/out_valid directly from flops.
module bit_permute_pipe
  import bit_permute_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  bit_permute_pipe_if.slave bus
);

  if (!width_is_valid(WIDTH)) begin : g_bad_width
    $error("bit_permute_pipe: WIDTH must be a multiple of 8 and at least 8");
  end
  if (!lenw_is_valid(WIDTH, LENW)) begin : g_bad_lenw
    $error("bit_permute_pipe: 2**LENW must exceed WIDTH");
  end

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  mode_t            r_s1_mode;
  logic [LENW-1:0]  r_s1_len;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;

  logic             w_s1_en;
  logic             w_s2_en;
  logic [WIDTH-1:0] w_perm;

  assign w_s2_en = !r_s2_valid || bus.out_ready;
  assign w_s1_en = !r_s1_valid || w_s2_en;

  bit_permute_pipe_permute_core #(
    .WIDTH (WIDTH),
    .LENW  (LENW)
  ) u_core (
    .i_data   (r_s1_data),
    .i_mode   (r_s1_mode),
    .i_len    (r_s1_len),
    .o_result (w_perm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= MODE_PASS;
      r_s1_len   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        // Hold the last result when S2 empties; only valid words load.
        if (r_s1_valid) begin
          r_s2_data <= w_perm;
        end
      end
      if (w_s1_en) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_data <= bus.in_data;
          r_s1_mode <= bus.in_mode;
          r_s1_len  <= bus.in_len;
        end
      end
    end
  end

  assign bus.in_ready  = w_s1_en;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.busy      = r_s1_valid || r_s2_valid;

endmodule
